// File: rtl/multi_box_pkg.sv
// -----------------------------------------------------------------------------
// multi_box_pkg
// Shared types and helpers for the multi_box_image bouncing-box generator.
//   POS_W / VEL_W    : storage widths of box coordinates and velocities.
//                      POS_W holds any legal coordinate plus a sign bit.
//   box_state_t      : per-box state (position, velocity, colour).
//   upd_state_t      : update sequencer states.
//   COLOR_FIRST/LAST : legal colour range; colour 0 (black) is never used.
//   next_colour()    : colour sequence 1..7, wrapping 7 -> 1.
// -----------------------------------------------------------------------------
package multi_box_pkg;

    localparam int POS_W   = 12;
    localparam int VEL_W   = 8;
    localparam int COLOR_W = 3;

    localparam logic [COLOR_W-1:0] COLOR_FIRST = 3'd1;
    localparam logic [COLOR_W-1:0] COLOR_LAST  = 3'd7;

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } upd_state_t;

    typedef struct packed {
        logic signed [POS_W-1:0]   x;
        logic signed [POS_W-1:0]   y;
        logic signed [VEL_W-1:0]   xv;
        logic signed [VEL_W-1:0]   yv;
        logic        [COLOR_W-1:0] colour;
    } box_state_t;

    function automatic logic [COLOR_W-1:0] next_colour(input logic [COLOR_W-1:0] c);
        return (c == COLOR_LAST) ? COLOR_FIRST : c + 1'b1;
    endfunction

endpackage

// File: rtl/multi_box_image_box_mover.sv
// -----------------------------------------------------------------------------
// box_mover
// Purely combinational next-state step for one box: advances position by
// velocity, clamps into the visible area and reflects velocity on a wall hit.
// Ports:
//   x, y          in  : current top-left corner (signed)
//   xv, yv        in  : current velocity (signed)
//   x_next,y_next out : clamped position after this frame
//   xv_next,yv_next out: velocity after this frame (negated on hit)
//   hit_x, hit_y  out : wall hit on each axis
// -----------------------------------------------------------------------------
module box_mover
    import multi_box_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int BOX_SIZE      = 64
) (
    input  logic signed [POS_W-1:0] x,
    input  logic signed [POS_W-1:0] y,
    input  logic signed [VEL_W-1:0] xv,
    input  logic signed [VEL_W-1:0] yv,
    output logic signed [POS_W-1:0] x_next,
    output logic signed [POS_W-1:0] y_next,
    output logic signed [VEL_W-1:0] xv_next,
    output logic signed [VEL_W-1:0] yv_next,
    output logic                    hit_x,
    output logic                    hit_y
);

    // Highest legal top-left coordinate on each axis.
    localparam logic signed [POS_W:0] X_LIM = (POS_W+1)'(SCREEN_WIDTH - BOX_SIZE);
    localparam logic signed [POS_W:0] Y_LIM = (POS_W+1)'(SCREEN_HEIGHT - BOX_SIZE);

    // One extra bit on the trial position so a step past either wall is
    // representable: sign bit set means below 0. Touching the far limit
    // exactly already counts as a hit so the box reverses while fully visible.
    function automatic void step_axis(
        input  logic signed [POS_W-1:0] p,
        input  logic signed [VEL_W-1:0] v,
        input  logic signed [POS_W:0]   lim,
        output logic signed [POS_W-1:0] p_next,
        output logic signed [VEL_W-1:0] v_next,
        output logic                    hit
    );
        logic signed [POS_W:0] t;
        t   = (POS_W+1)'(p) + (POS_W+1)'(v);
        hit = t[POS_W] || (t >= lim);
        if (t[POS_W])
            p_next = '0;
        else if (t >= lim)
            p_next = lim[POS_W-1:0];
        else
            p_next = t[POS_W-1:0];
        v_next = hit ? -v : v;
    endfunction

    always_comb begin
        step_axis(x, xv, X_LIM, x_next, xv_next, hit_x);
        step_axis(y, yv, Y_LIM, y_next, yv_next, hit_y);
    end

endmodule

// File: rtl/multi_box_image.sv
// -----------------------------------------------------------------------------
// multi_box_image
// Draws NUM_BOXES square boxes that bounce around the screen. Once per frame
// (frame_tick, outside pause) the boxes are stepped one per clock through a
// single shared box_mover. Pixel colour is a registered lookup of the current
// beam position against all boxes; the lowest-numbered box wins on overlap.
//
// Ports:
//   clk, rst               : pixel clock, synchronous active-high reset
//   position_x, position_y : current beam position
//   frame_tick             : one-cycle per-frame pulse (vertical blank)
//   pause                  : freeze motion while high
//   r, g, b                : 4-bit colour, one cycle after the position
//   update_busy            : high while box states are being stepped
//   overrun                : sticky; frame_tick arrived during an update
//
// Build option:
//   MULTI_BOX_COLOR_CYCLE_EN : when defined, a box advances its colour
//                              (1..7, wrapping) on every wall hit; otherwise
//                              colours keep their reset values.
// -----------------------------------------------------------------------------
module multi_box_image
    import multi_box_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int NUM_BOXES     = 4,
    parameter int BOX_SIZE      = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [$clog2(SCREEN_WIDTH)-1:0]  position_x,
    input  logic [$clog2(SCREEN_HEIGHT)-1:0] position_y,
    input  logic                             frame_tick,
    input  logic                             pause,
    output logic [3:0]                       r,
    output logic [3:0]                       g,
    output logic [3:0]                       b,
    output logic                             update_busy,
    output logic                             overrun
);

`ifdef MULTI_BOX_COLOR_CYCLE_EN
    localparam bit COLOR_CYCLE = 1'b1;
`else
    localparam bit COLOR_CYCLE = 1'b0;
`endif

    localparam int IDX_W = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;
    localparam logic [POS_W:0] BOX_EXT = (POS_W+1)'(BOX_SIZE);

    // Parameter legality, caught at elaboration.
    if (NUM_BOXES < 1 || NUM_BOXES > 8) begin : g_bad_num_boxes
        $error("multi_box_image: NUM_BOXES must be in 1..8");
    end
    if (NUM_BOXES * BOX_SIZE / 2 > SCREEN_WIDTH - BOX_SIZE) begin : g_bad_width
        $error("multi_box_image: initial box x positions exceed screen width");
    end
    if (NUM_BOXES * BOX_SIZE / 4 > SCREEN_HEIGHT - BOX_SIZE) begin : g_bad_height
        $error("multi_box_image: initial box y positions exceed screen height");
    end
    if ($clog2(SCREEN_WIDTH) + 1 > POS_W || $clog2(SCREEN_HEIGHT) + 1 > POS_W) begin : g_bad_pos_w
        $error("multi_box_image: screen too large for package coordinate width");
    end

    function automatic box_state_t reset_box(input int i);
        box_state_t bs;
        bs.x      = POS_W'(i * (BOX_SIZE / 2));
        bs.y      = POS_W'(i * (BOX_SIZE / 4));
        bs.xv     = VEL_W'(1 + (i % 3));
        bs.yv     = VEL_W'(1 + (i % 2));
        bs.colour = COLOR_W'((i % 7) + 1);
        return bs;
    endfunction

    upd_state_t              state;
    logic [IDX_W-1:0]        idx;
    box_state_t              boxes [NUM_BOXES];
    box_state_t              cur_box;
    box_state_t              nxt_box;
    logic signed [POS_W-1:0] nxt_x, nxt_y;
    logic signed [VEL_W-1:0] nxt_xv, nxt_yv;
    logic                    hit_x, hit_y;

    // Select the box being stepped this cycle.
    always_comb begin
        cur_box = boxes[0];
        for (int i = 1; i < NUM_BOXES; i++) begin
            if (idx == IDX_W'(i))
                cur_box = boxes[i];
        end
    end

    box_mover #(
        .SCREEN_WIDTH  (SCREEN_WIDTH),
        .SCREEN_HEIGHT (SCREEN_HEIGHT),
        .BOX_SIZE      (BOX_SIZE)
    ) u_box_mover (
        .x       (cur_box.x),
        .y       (cur_box.y),
        .xv      (cur_box.xv),
        .yv      (cur_box.yv),
        .x_next  (nxt_x),
        .y_next  (nxt_y),
        .xv_next (nxt_xv),
        .yv_next (nxt_yv),
        .hit_x   (hit_x),
        .hit_y   (hit_y)
    );

    // A corner hit reflects both axes but advances the colour only once.
    always_comb begin
        nxt_box    = cur_box;
        nxt_box.x  = nxt_x;
        nxt_box.y  = nxt_y;
        nxt_box.xv = nxt_xv;
        nxt_box.yv = nxt_yv;
        if (COLOR_CYCLE && (hit_x || hit_y))
            nxt_box.colour = next_colour(cur_box.colour);
    end

    // Update sequencer: one box per cycle, then back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < NUM_BOXES; i++)
                boxes[i] <= reset_box(i);
        end else begin
            case (state)
                IDLE: begin
                    if (frame_tick && !pause) begin
                        state <= UPDATE;
                        idx   <= '0;
                    end
                end
                UPDATE: begin
                    // A new frame request cannot be honoured mid-update.
                    if (frame_tick && !pause)
                        overrun <= 1'b1;
                    for (int i = 0; i < NUM_BOXES; i++) begin
                        if (idx == IDX_W'(i))
                            boxes[i] <= nxt_box;
                    end
                    if (idx == IDX_W'(NUM_BOXES - 1)) begin
                        state <= IDLE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign update_busy = (state == UPDATE);

    // ---- stage p0: hit-test beam position against every box ----
    logic [POS_W:0]         px_p0, py_p0;
    logic [POS_W:0]         bx, by;
    logic [COLOR_W-1:0]     pix_colour_p0;

    assign px_p0 = (POS_W+1)'(position_x);
    assign py_p0 = (POS_W+1)'(position_y);

    // Walk from the highest index down so the lowest index is written last.
    always_comb begin
        pix_colour_p0 = '0;
        bx            = '0;
        by            = '0;
        for (int i = NUM_BOXES - 1; i >= 0; i--) begin
            bx = {1'b0, boxes[i].x};
            by = {1'b0, boxes[i].y};
            if (px_p0 >= bx && px_p0 < bx + BOX_EXT &&
                py_p0 >= by && py_p0 < by + BOX_EXT)
                pix_colour_p0 = boxes[i].colour;
        end
    end

    // ---- stage p1: registered colour output ----
    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
            g <= '0;
            b <= '0;
        end else begin
            r <= {4{pix_colour_p0[0]}};
            g <= {4{pix_colour_p0[1]}};
            b <= {4{pix_colour_p0[2]}};
        end
    end

endmodule

// File: tb/tb_multi_box_image.sv
module tb_multi_box_image;

    localparam int SW = 640;
    localparam int SH = 480;
    localparam int XW = $clog2(SW);
    localparam int YW = $clog2(SH);

`ifdef MULTI_BOX_COLOR_CYCLE_EN
    localparam bit CYC = 1'b1;
`else
    localparam bit CYC = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst1, rst4, tick1, tick4, pause1, pause4;
    logic [XW-1:0] px;
    logic [YW-1:0] py;
    logic [3:0]    r1, g1, b1, r4, g4, b4;
    logic          busy1, busy4, ovr1, ovr4;

    multi_box_image #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .NUM_BOXES(1), .BOX_SIZE(64)) dut1 (
        .clk(clk), .rst(rst1), .position_x(px), .position_y(py),
        .frame_tick(tick1), .pause(pause1), .r(r1), .g(g1), .b(b1),
        .update_busy(busy1), .overrun(ovr1)
    );

    multi_box_image #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH), .NUM_BOXES(4), .BOX_SIZE(64)) dut4 (
        .clk(clk), .rst(rst4), .position_x(px), .position_y(py),
        .frame_tick(tick4), .pause(pause4), .r(r4), .g(g4), .b(b4),
        .update_busy(busy4), .overrun(ovr4)
    );

    typedef struct {
        bit          sel4;
        logic [11:0] rgb;
        logic        busy;
        logic        ovr;
        string       name;
    } exp_t;

    exp_t sb[$];
    bit   probe = 1'b0, probe_d = 1'b0, end_req = 1'b0, end_done = 1'b0;
    int   n_tests = 0, n_fail = 0;

    function automatic logic [11:0] col(input int c);
        logic [2:0] cb;
        cb = 3'(c);
        return {{4{cb[0]}}, {4{cb[1]}}, {4{cb[2]}}};
    endfunction

    always @(posedge clk) probe_d <= probe;

    // Monitor: compares every sampled output against the scoreboard head.
    always @(negedge clk) begin
        exp_t        e;
        logic [11:0] a_rgb;
        logic        a_busy, a_ovr;
        if (probe_d) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: output sampled with no expectation queued");
            end else begin
                e      = sb.pop_front();
                a_rgb  = e.sel4 ? {r4, g4, b4} : {r1, g1, b1};
                a_busy = e.sel4 ? busy4 : busy1;
                a_ovr  = e.sel4 ? ovr4 : ovr1;
                if (a_rgb !== e.rgb || a_busy !== e.busy || a_ovr !== e.ovr) begin
                    n_fail++;
                    $display("FAIL %s: got rgb=%h busy=%b ovr=%b, expected rgb=%h busy=%b ovr=%b",
                             e.name, a_rgb, a_busy, a_ovr, e.rgb, e.busy, e.ovr);
                end
            end
        end
        if (end_req && !end_done) begin
            n_tests++;
            if (sb.size() != 0) begin
                n_fail++;
                $display("FAIL sb_leftover: got %0d entries, expected 0", sb.size());
            end
            end_done = 1'b1;
        end
    end

    task automatic step(input bit chk, input bit sel4, input int x, input int y,
                        input logic [11:0] ergb, input logic ebusy, input logic eovr,
                        input string name);
        exp_t e;
        px = XW'(x);
        py = YW'(y);
        if (chk) begin
            e.sel4 = sel4; e.rgb = ergb; e.busy = ebusy; e.ovr = eovr; e.name = name;
            sb.push_back(e);
        end
        probe = chk;
        @(posedge clk); #1;
        probe = 1'b0;
    endtask

    task automatic c1(input int x, input int y, input logic [11:0] ergb, input string name);
        step(1'b1, 1'b0, x, y, ergb, 1'b0, 1'b0, name);
    endtask

    task automatic c4(input int x, input int y, input logic [11:0] ergb, input logic eovr, input string name);
        step(1'b1, 1'b1, x, y, ergb, 1'b0, eovr, name);
    endtask

    task automatic run_ticks1(input int n);
        for (int i = 0; i < n; i++) begin
            tick1 = 1'b1;
            step(1'b0, 1'b0, 0, 0, 12'h000, 1'b0, 1'b0, "");
            tick1 = 1'b0;
            step(1'b0, 1'b0, 0, 0, 12'h000, 1'b0, 1'b0, "");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish within time budget");
        $fatal(1, "timeout");
    end

    initial begin
        rst1 = 1'b1; rst4 = 1'b1; tick1 = 1'b0; tick4 = 1'b0;
        pause1 = 1'b0; pause4 = 1'b0; px = '0; py = '0;
        @(posedge clk); #1;
        step(1'b1, 1'b0, 0, 0, 12'h000, 1'b0, 1'b0, "rst_out_d1");
        step(1'b1, 1'b1, 40, 20, 12'h000, 1'b0, 1'b0, "rst_out_d4");
        rst1 = 1'b0; rst4 = 1'b0;

        // ---------------- 4-box instance ----------------
        c4(40, 20, col(1), 1'b0, "overlap_b0_wins");
        c4(70, 20, col(2), 1'b0, "box1_only");
        c4(100, 40, col(3), 1'b0, "box2_only");
        c4(130, 100, col(4), 1'b0, "box3_only");
        c4(639, 479, col(0), 1'b0, "outside_all");

        pause4 = 1'b1; tick4 = 1'b1;
        c4(0, 0, col(1), 1'b0, "pause_tick_ignored");
        pause4 = 1'b0; tick4 = 1'b0;
        c4(0, 0, col(1), 1'b0, "pause_no_motion");

        tick4 = 1'b1; step(1'b1, 1'b1, 639, 479, 12'h000, 1'b1, 1'b0, "ovr_busy_t1");
        tick4 = 1'b0; step(1'b1, 1'b1, 639, 479, 12'h000, 1'b1, 1'b0, "ovr_busy_t2");
        tick4 = 1'b1; step(1'b1, 1'b1, 639, 479, 12'h000, 1'b1, 1'b1, "ovr_busy_t3");
        tick4 = 1'b0; step(1'b1, 1'b1, 639, 479, 12'h000, 1'b1, 1'b1, "ovr_busy_t4");
        step(1'b1, 1'b1, 639, 479, 12'h000, 1'b0, 1'b1, "ovr_idle_t5");
        c4(0, 0, col(0), 1'b1, "upd_b0_left_origin");
        c4(1, 1, col(1), 1'b1, "upd_b0_moved");
        c4(66, 19, col(2), 1'b1, "upd_b1_moved");
        c4(130, 33, col(3), 1'b1, "upd_b2_once");
        c4(130, 32, col(0), 1'b1, "upd_b2_top_edge");
        c4(160, 113, col(4), 1'b1, "upd_b3_corner");
        c4(161, 50, col(0), 1'b1, "upd_b3_right_edge");

        tick4 = 1'b1; step(1'b1, 1'b1, 639, 479, 12'h000, 1'b1, 1'b1, "rstmid_busy1");
        tick4 = 1'b0; step(1'b1, 1'b1, 639, 479, 12'h000, 1'b1, 1'b1, "rstmid_busy2");
        rst4 = 1'b1;  step(1'b1, 1'b1, 639, 479, 12'h000, 1'b0, 1'b0, "rstmid_cleared");
        rst4 = 1'b0;
        c4(0, 0, col(1), 1'b0, "rstmid_b0_home");
        c4(40, 20, col(1), 1'b0, "rstmid_overlap");
        c4(70, 20, col(2), 1'b0, "rstmid_b1_home");
        c4(130, 100, col(4), 1'b0, "rstmid_b3_home");

        // ---------------- 1-box instance ----------------
        c1(0, 0, col(1), "d1_origin");
        c1(63, 63, col(1), "d1_far_corner");
        c1(64, 0, col(0), "d1_right_out");
        c1(0, 64, col(0), "d1_below_out");
        tick1 = 1'b1; step(1'b1, 1'b0, 0, 0, col(1), 1'b1, 1'b0, "d1_busy_cycle");
        tick1 = 1'b0; step(1'b1, 1'b0, 0, 0, col(1), 1'b0, 1'b0, "d1_busy_one_cycle");
        c1(0, 0, col(0), "d1_step_left_origin");
        c1(1, 1, col(1), "d1_step_xy1");
        c1(64, 64, col(1), "d1_step_far");
        c1(65, 1, col(0), "d1_step_right_out");

        pause1 = 1'b1; tick1 = 1'b1;
        c1(1, 1, col(1), "d1_pause_tick");
        pause1 = 1'b0; tick1 = 1'b0;
        c1(1, 1, col(1), "d1_pause_hold");
        c1(2, 65, col(0), "d1_pause_no_move");

        // k = 575: x = 575, y = 257 (y reflected at 416)
        run_ticks1(574);
        c1(575, 257, col(CYC ? 2 : 1), "k575_corner");
        c1(574, 257, col(0), "k575_left_out");
        c1(575, 256, col(0), "k575_above_out");
        c1(638, 320, col(CYC ? 2 : 1), "k575_far");
        c1(639, 320, col(0), "k575_far_out");
        // k = 576: trial 576 reaches the right limit -> clamp, xv -> -1
        run_ticks1(1);
        c1(576, 256, col(CYC ? 3 : 1), "k576_clamp");
        c1(575, 256, col(0), "k576_left_out");
        c1(639, 319, col(CYC ? 3 : 1), "k576_screen_edge");
        // k = 577: moving left now
        run_ticks1(1);
        c1(575, 255, col(CYC ? 3 : 1), "k577_reversed");
        c1(639, 255, col(0), "k577_right_out");
        // k = 1152: x = 0, y = 319 (y reflected at 0 on k = 833)
        run_ticks1(575);
        c1(0, 319, col(CYC ? 4 : 1), "k1152_origin");
        // k = 1153: trial x = -1 -> clamp to 0, xv -> +1
        run_ticks1(1);
        c1(0, 320, col(CYC ? 5 : 1), "k1153_clamp0");
        c1(0, 319, col(0), "k1153_above_out");
        c1(63, 383, col(CYC ? 5 : 1), "k1153_far");
        c1(64, 320, col(0), "k1153_right_out");
        run_ticks1(1);
        c1(1, 321, col(CYC ? 5 : 1), "k1154_bounced");
        c1(0, 321, col(0), "k1154_left_out");

        end_req = 1'b1;
        for (int i = 0; i < 10 && !end_done; i++) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_box_image.md
MULTI_BOX_IMAGE -- requirements
Module: multi_box_image

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 640, visible pixels per line.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 480, visible lines per frame.
REQ-003 SHALL have parameter NUM_BOXES, default 4, legal range 1..8, number of independent bouncing boxes.
REQ-004 SHALL have parameter BOX_SIZE, default 64, edge length of each square box in pixels.
REQ-005 SHALL have port clk, input, 1 bit, pixel clock; one clock only.
REQ-006 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port position_x, input, $clog2(SCREEN_WIDTH) bits, current pixel column.
REQ-008 SHALL have port position_y, input, $clog2(SCREEN_HEIGHT) bits, current pixel row.
REQ-009 SHALL have port frame_tick, input, 1 bit, single-cycle pulse per frame, issued during vertical blank.
REQ-010 SHALL have port pause, input, 1 bit, freeze motion while high.
REQ-011 SHALL have ports r, g, b, output, 4 bits each, pixel colour.
REQ-012 SHALL have port update_busy, output, 1 bit, high while box states are being updated.
REQ-013 SHALL have port overrun, output, 1 bit, sticky flag: frame_tick arrived while busy.

Function
REQ-014 Per box i: signed x, y (width $clog2(dim)+1), signed velocities xv, yv, 3-bit colour (never 0).
REQ-015 FSM states IDLE, UPDATE; IDLE -> UPDATE on frame_tick && !pause; box index cleared to 0 on entry.
REQ-016 In UPDATE, exactly one box (current index) updated per cycle; after index NUM_BOXES-1 return to IDLE; update_busy = (state == UPDATE).
REQ-017 Trajectory tx = x + xv; x_next = clamp(tx, 0, SCREEN_WIDTH-BOX_SIZE); same for y with SCREEN_HEIGHT.
REQ-018 Hit if tx < 0 or tx >= SCREEN_WIDTH-BOX_SIZE; on hit xv_next = -xv, else xv unchanged; same for y.
REQ-019 Simultaneous x and y hit negates both velocities; colour advances once.
REQ-020 frame_tick while UPDATE ignored and sets overrun; frame_tick with pause high ignored without setting overrun.
REQ-021 Pixel inside box i iff x_i <= position_x < x_i+BOX_SIZE and y_i <= position_y < y_i+BOX_SIZE.
REQ-022 Overlap: lowest index wins; box pixel = {4{colour bit}} per channel (r=bit0, g=bit1, b=bit2); outside all boxes = 0.
REQ-023 r, g, b registered: one-cycle latency from position_x/position_y to colour.
REQ-024 Full update latency = NUM_BOXES cycles after frame_tick accepted.

Reset
REQ-025 On rst: state IDLE, index 0, update_busy 0, overrun 0, r/g/b 0.
REQ-026 On rst box i: x = i*(BOX_SIZE/2), y = i*(BOX_SIZE/4), xv = 1+(i mod 3), yv = 1+(i mod 2), colour = (i mod 7)+1.
REQ-027 rst mid-UPDATE aborts the update; all state takes reset values next cycle.
REQ-028 Only legal parameters: NUM_BOXES*BOX_SIZE/2 <= SCREEN_WIDTH-BOX_SIZE and NUM_BOXES*BOX_SIZE/4 <= SCREEN_HEIGHT-BOX_SIZE; elaboration error otherwise.

Configuration
REQ-029 Macro MULTI_BOX_COLOR_CYCLE_EN: defined -> on any hit colour advances 1..7, 7 wraps to 1; undefined -> colour holds reset value forever.

Structure
REQ-030 Package multi_box_pkg SHALL hold box state typedef, colour width, first/last colour constants, next-colour function.
REQ-031 Sub-module box_mover SHALL compute one box's next x, y, xv, yv, hit flags; instantiated once, muxed by index.

Verification
REQ-032 Reset, NUM_BOXES=1: x=0,y=0,xv=1,yv=1,colour=1; one frame_tick -> x=1,y=1 after 1 cycle; busy high exactly 1 cycle.
REQ-033 Box 0 at x=575 (640-64-1), xv=2: frame_tick -> x=576, xv=-2, colour 1->2 (macro defined) / stays 1 (undefined).
REQ-034 Boxes 0 and 1 overlap at pixel (40,20): output = box 0 colour, one cycle after position presented.
REQ-035 NUM_BOXES=4: frame_tick at t, second frame_tick at t+2 -> busy cycles t+1..t+4, overrun=1, positions updated once.
REQ-036 pause=1 with frame_tick -> no state change, overrun=0; rst at second UPDATE cycle -> all reset values next cycle.
